// File: rtl/wb_mem_pkg.sv
// Shared definitions for the Wishbone memory master:
// size and error codes, FSM states and a clog2 helper.
package wb_mem_pkg;

    localparam logic [1:0] SZ_BYTE  = 2'd0;
    localparam logic [1:0] SZ_HALF  = 2'd1;
    localparam logic [1:0] SZ_WORD  = 2'd2;
    localparam logic [1:0] SZ_DWORD = 2'd3;

    localparam logic [1:0] ERR_OK      = 2'd0;
    localparam logic [1:0] ERR_BUS     = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT = 2'd2;
    localparam logic [1:0] ERR_ALIGN   = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_RESP = 2'd3
    } state_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/wb_lane_align.sv
// Byte-lane steering: store replication and select generation,
// load extraction with zero or sign extension.
module wb_lane_align
    import wb_mem_pkg::*;
#(
    parameter  int DATA_W = 32,
    localparam int SEL_W  = DATA_W / 8,
    localparam int OFF_W  = clog2(SEL_W)
) (
    input  logic [OFF_W-1:0]  st_off,
    input  logic [1:0]        st_size,
    input  logic [DATA_W-1:0] st_data,
    output logic [DATA_W-1:0] wb_data,
    output logic [SEL_W-1:0]  sel,
    input  logic [OFF_W-1:0]  ld_off,
    input  logic [1:0]        ld_size,
    input  logic              ld_sgn,
    input  logic [DATA_W-1:0] ld_data,
    output logic [DATA_W-1:0] rsp_data
);

    localparam int SW = SEL_W + 8;
    typedef logic [SW-1:0] selw_t;

    logic [3:0]        st_nb;
    logic [3:0]        ld_nb;
    selw_t             sel_wide;
    logic [DATA_W-1:0] shifted;
    logic              sbit;

    // Replicate the right-aligned store data and build the byte selects.
    always_comb begin
        st_nb    = 4'd1 << st_size;
        wb_data  = '0;
        for (int i = 0; i < SEL_W; i++) begin
            wb_data[8*i +: 8] =
                st_data[8*(i & (int'(st_nb) - 1)) +: 8];
        end
        sel_wide = ((selw_t'(1) << st_nb) - selw_t'(1)) << st_off;
        sel      = sel_wide[SEL_W-1:0];
    end

    // Shift the addressed lanes down and extend from the top loaded bit.
    always_comb begin
        ld_nb    = 4'd1 << ld_size;
        shifted  = ld_data >> {ld_off, 3'b000};
        unique case (ld_size)
            SZ_BYTE:  sbit = shifted[7];
            SZ_HALF:  sbit = shifted[15];
            SZ_WORD:  sbit = shifted[31];
            SZ_DWORD: sbit = shifted[DATA_W-1];
            default:  sbit = 1'b0;
        endcase
        rsp_data = '0;
        for (int k = 0; k < DATA_W; k++) begin
            if (k < 8 * int'(ld_nb))
                rsp_data[k] = shifted[k];
            else
                rsp_data[k] = ld_sgn & sbit;
        end
    end

endmodule

// File: rtl/wb_mem_master.sv
// Wishbone B4 pipelined master for CPU fetch/load/store,
// one transaction outstanding, with stall, error and watchdog.
module wb_mem_master
    import wb_mem_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int SEL_W   = DATA_W / 8,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_req_valid,
    output logic              o_req_ready,
    input  logic [ADDR_W-1:0] i_req_addr,
    input  logic              i_req_we,
    input  logic [DATA_W-1:0] i_req_data,
    input  logic [1:0]        i_req_size,
    input  logic              i_req_signed,
    output logic              o_rsp_valid,
    output logic [DATA_W-1:0] o_rsp_data,
    output logic [1:0]        o_rsp_err,
    output logic              o_wb_cyc,
    output logic              o_wb_stb,
    output logic              o_wb_we,
    output logic [ADDR_W-1:0] o_wb_addr,
    output logic [DATA_W-1:0] o_wb_data,
    output logic [SEL_W-1:0]  o_wb_sel,
    input  logic              i_wb_stall,
    input  logic              i_wb_ack,
    input  logic              i_wb_err,
    input  logic [DATA_W-1:0] i_wb_data
);

    localparam int OFF_W = clog2(SEL_W);
    localparam int CNT_W = (TIMEOUT < 2) ? 1 : clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] TMAX = CNT_W'(TIMEOUT - 1);

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [OFF_W-1:0]  off_q;
    logic [1:0]        size_q;
    logic              sgn_q;
    logic              we_q;

    logic [DATA_W-1:0] st_rep;
    logic [SEL_W-1:0]  st_sel;
    logic [DATA_W-1:0] ld_ext;
    logic [3:0]        amask;
    logic              bad;

    assign o_req_ready = (state == ST_IDLE);

    wb_lane_align #(.DATA_W(DATA_W)) u_align (
        .st_off   (i_req_addr[OFF_W-1:0]),
        .st_size  (i_req_size),
        .st_data  (i_req_data),
        .wb_data  (st_rep),
        .sel      (st_sel),
        .ld_off   (off_q),
        .ld_size  (size_q),
        .ld_sgn   (sgn_q),
        .ld_data  (i_wb_data),
        .rsp_data (ld_ext)
    );

    // Reject misaligned requests and dwords on a 32-bit bus.
    always_comb begin
        amask = (4'd1 << i_req_size) - 4'd1;
        bad   = (|(i_req_addr[2:0] & amask[2:0])) ||
                (DATA_W == 32 && i_req_size == SZ_DWORD);
    end

    // Request FSM with registered bus/response outputs and watchdog.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            off_q       <= '0;
            size_q      <= SZ_BYTE;
            sgn_q       <= 1'b0;
            we_q        <= 1'b0;
            o_wb_cyc    <= 1'b0;
            o_wb_stb    <= 1'b0;
            o_wb_we     <= 1'b0;
            o_wb_addr   <= '0;
            o_wb_data   <= '0;
            o_wb_sel    <= '0;
            o_rsp_valid <= 1'b0;
            o_rsp_err   <= ERR_OK;
            o_rsp_data  <= '0;
        end else begin
            o_rsp_valid <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (i_req_valid) begin
                        off_q      <= i_req_addr[OFF_W-1:0];
                        size_q     <= i_req_size;
                        sgn_q      <= i_req_signed;
                        we_q       <= i_req_we;
                        o_rsp_data <= '0;
                        if (bad) begin
                            o_rsp_err   <= ERR_ALIGN;
                            o_rsp_valid <= 1'b1;
                            state       <= ST_RESP;
                        end else begin
                            o_wb_cyc  <= 1'b1;
                            o_wb_stb  <= 1'b1;
                            o_wb_we   <= i_req_we;
                            o_wb_addr <= {i_req_addr[ADDR_W-1:OFF_W],
                                          {OFF_W{1'b0}}};
                            o_wb_data <= st_rep;
                            o_wb_sel  <= st_sel;
                            cnt       <= '0;
                            state     <= ST_REQ;
                        end
                    end
                end
                ST_REQ, ST_WAIT: begin
                    if (i_wb_ack || i_wb_err) begin
                        o_wb_cyc    <= 1'b0;
                        o_wb_stb    <= 1'b0;
                        o_wb_we     <= 1'b0;
                        o_rsp_valid <= 1'b1;
                        state       <= ST_RESP;
                        if (i_wb_err) begin
                            o_rsp_err  <= ERR_BUS;
                            o_rsp_data <= '0;
                        end else begin
                            o_rsp_err  <= ERR_OK;
                            o_rsp_data <= we_q ? '0 : ld_ext;
                        end
                    end else if (TIMEOUT != 0 && cnt == TMAX) begin
                        o_wb_cyc    <= 1'b0;
                        o_wb_stb    <= 1'b0;
                        o_wb_we     <= 1'b0;
                        o_rsp_valid <= 1'b1;
                        o_rsp_err   <= ERR_TIMEOUT;
                        o_rsp_data  <= '0;
                        state       <= ST_RESP;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                        if (state == ST_REQ && !i_wb_stall) begin
                            o_wb_stb <= 1'b0;
                            state    <= ST_WAIT;
                        end
                    end
                end
                ST_RESP: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
